// File: rtl/branch_pkg.sv
// Shared types for the branch resolution stage: condition codes, FSM states and
// the default datapath width.
package branch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    CondEq  = 3'b000,
    CondNe  = 3'b001,
    CondLt  = 3'b100,
    CondGe  = 3'b101,
    CondLtu = 3'b110,
    CondGeu = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    StIdle,
    StFull,
    StFlush
  } state_e;

endpackage

// File: rtl/branch_resolve.sv
// Resolves branch/jal/jalr ops into a registered result, redirects fetch on taken
// aligned legal ops and stalls the input for FLUSH_CYCLES after each redirect.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            cmp_eq,
  input  logic            cmp_lt,
  input  logic            cmp_ltu,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] link,
  output logic            misalign,
  output logic            illegal,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [15:0]     taken_cnt
);

  state_e          state_q, state_d;
  logic [3:0]      flush_cnt_q, flush_cnt_d;
  logic            taken_q, taken_d;
  logic            misalign_q, misalign_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] link_q, link_d;
  logic [15:0]     taken_cnt_q, taken_cnt_d;

  logic            cond_ok, cond_ill;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic            accept, out_hs, held_redirects;

  // Decode the branch condition from the upstream comparator flags.
  always_comb begin
    cond_ok  = 1'b0;
    cond_ill = 1'b0;
    case (cond_e'(funct3))
      CondEq:  cond_ok = cmp_eq;
      CondNe:  cond_ok = ~cmp_eq;
      CondLt:  cond_ok = cmp_lt;
      CondGe:  cond_ok = ~cmp_lt;
      CondLtu: cond_ok = cmp_ltu;
      CondGeu: cond_ok = ~cmp_ltu;
      default: cond_ill = 1'b1;
    endcase
  end

  always_comb begin
    res_taken  = is_jal | is_jalr | (is_branch & cond_ok & ~cond_ill);
    res_target = (is_jalr ? rs1 : pc) + imm;
    if (is_jalr) res_target[0] = 1'b0;
  end

  assign held_redirects = taken_q & ~misalign_q & ~illegal_q;
  assign out_hs         = out_valid & out_ready;
  assign accept         = in_valid & in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StFull;
      StFull: begin
        if (out_ready) begin
          if (held_redirects) begin
            state_d     = StFlush;
            flush_cnt_d = 4'(FLUSH_CYCLES);
          end else if (!accept) begin
            state_d = StIdle;
          end
        end
      end
      StFlush: begin
        flush_cnt_d = flush_cnt_q - 4'd1;
        if (flush_cnt_q <= 4'd1) begin
          state_d     = StIdle;
          flush_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic; a redirecting held result blocks new input in its handshake cycle.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle:  in_ready = 1'b1;
      StFull: begin
        out_valid = 1'b1;
        in_ready  = out_ready & ~held_redirects;
      end
      StFlush: in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
    redirect    = out_hs & held_redirects;
    redirect_pc = redirect ? target_q : '0;
  end

  always_comb begin
    taken_d     = taken_q;
    misalign_d  = misalign_q;
    illegal_d   = illegal_q;
    target_d    = target_q;
    link_d      = link_q;
    taken_cnt_d = taken_cnt_q;
    if (accept) begin
      taken_d    = res_taken;
      misalign_d = res_taken & res_target[1];
      illegal_d  = is_branch & cond_ill;
      target_d   = res_target;
      link_d     = pc + XLEN'(4);
    end
    if (out_hs && taken_q && (taken_cnt_q != 16'hFFFF)) taken_cnt_d = taken_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_q     <= 1'b0;
      misalign_q  <= 1'b0;
      illegal_q   <= 1'b0;
      target_q    <= '0;
      link_q      <= '0;
      taken_cnt_q <= '0;
    end else begin
      taken_q     <= taken_d;
      misalign_q  <= misalign_d;
      illegal_q   <= illegal_d;
      target_q    <= target_d;
      link_q      <= link_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign taken     = taken_q;
  assign misalign  = misalign_q;
  assign illegal   = illegal_q;
  assign target    = target_q;
  assign link      = link_q;
  assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios followed by a
// randomized run against a transaction-level reference model.
module tb_branch_resolve;

  localparam int XLEN = 32;
  localparam int FLUSH = 2;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, is_branch, is_jal, is_jalr;
  logic [2:0]      funct3;
  logic [XLEN-1:0] pc, imm, rs1;
  logic            cmp_eq, cmp_lt, cmp_ltu, out_valid, out_ready;
  logic            taken, misalign, illegal, redirect;
  logic [XLEN-1:0] target, link, redirect_pc;
  logic [15:0]     taken_cnt;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_resolve #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
    .pc(pc), .imm(imm), .rs1(rs1), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .target(target),
    .link(link), .misalign(misalign), .illegal(illegal), .redirect(redirect),
    .redirect_pc(redirect_pc), .taken_cnt(taken_cnt)
  );

  typedef struct {
    logic            taken;
    logic            misalign;
    logic            illegal;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
  } res_t;

  // Reference: what the instruction means architecturally.
  function automatic res_t model_resolve();
    res_t r;
    bit ok;
    bit bad;
    logic [XLEN-1:0] t;
    ok = 0;
    bad = 0;
    case (funct3)
      3'd0: ok = cmp_eq;
      3'd1: ok = !cmp_eq;
      3'd4: ok = cmp_lt;
      3'd5: ok = !cmp_lt;
      3'd6: ok = cmp_ltu;
      3'd7: ok = !cmp_ltu;
      default: bad = 1;
    endcase
    if (is_jalr) t = (rs1 + imm) & ~32'd1;
    else t = pc + imm;
    r.target = t;
    r.link = pc + 32'd4;
    r.illegal = is_branch && bad;
    r.taken = is_jal || is_jalr || (is_branch && ok && !bad);
    r.misalign = r.taken && t[1];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int kind, input logic [2:0] f3, input logic [31:0] p,
                        input logic [31:0] im, input logic [31:0] r1, input logic eq,
                        input logic lt, input logic ltu);
    is_branch = (kind == 1);
    is_jal = (kind == 2);
    is_jalr = (kind == 3);
    funct3 = f3;
    pc = p;
    imm = im;
    rs1 = r1;
    cmp_eq = eq;
    cmp_lt = lt;
    cmp_ltu = ltu;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 0;
    set_op(0, 3'd0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_checks++; if ({taken, misalign, illegal, redirect} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got=%b want=0000", {taken, misalign, illegal, redirect}); end
    n_checks++; if ({target, link, redirect_pc} !== 96'd0) begin n_fail++; $display("FAIL reset_data got=%h/%h/%h want=0", target, link, redirect_pc); end
    n_checks++; if (taken_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d want=0", taken_cnt); end
  endtask

  task automatic test_beq_redirect();
    set_op(1, 3'd0, 32'h100, 32'h20, 0, 1, 0, 0);
    in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1 || taken !== 1'b1) begin n_fail++; $display("FAIL beq_valid_taken got=%b%b want=11", out_valid, taken); end
    n_checks++; if (target !== 32'h120 || link !== 32'h104) begin n_fail++; $display("FAIL beq_target_link got=%h/%h want=120/104", target, link); end
    out_ready = 1;
    #1;
    n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h120) begin n_fail++; $display("FAIL beq_redirect got=%b/%h want=1/120", redirect, redirect_pc); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL beq_hs_in_ready got=%b want=0", in_ready); end
    tick();
    n_checks++; if (in_ready !== 1'b0 || redirect !== 1'b0 || redirect_pc !== 0) begin n_fail++; $display("FAIL flush1 got=%b/%b/%h want=0/0/0", in_ready, redirect, redirect_pc); end
    n_checks++; if (taken_cnt !== 16'd1) begin n_fail++; $display("FAIL beq_cnt got=%0d want=1", taken_cnt); end
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush2 got=%b want=0", in_ready); end
    tick();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_end got=%b/%b want=1/0", in_ready, out_valid); end
  endtask

  task automatic test_back_to_back();
    set_op(1, 3'd7, 32'h200, 32'h40, 0, 0, 0, 1);
    in_valid = 1; out_ready = 0;
    tick();
    n_checks++; if (out_valid !== 1'b1 || taken !== 1'b0) begin n_fail++; $display("FAIL bgeu got=%b%b want=10", out_valid, taken); end
    set_op(1, 3'd1, 32'h300, 32'h8, 0, 1, 0, 0);
    out_ready = 1;
    #1;
    n_checks++; if (in_ready !== 1'b1 || redirect !== 1'b0) begin n_fail++; $display("FAIL b2b_hs got=%b/%b want=1/0", in_ready, redirect); end
    tick();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1 || link !== 32'h304 || taken !== 1'b0) begin n_fail++; $display("FAIL b2b_second got=%b/%h/%b want=1/304/0", out_valid, link, taken); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || taken_cnt !== 16'd1) begin n_fail++; $display("FAIL b2b_drain got=%b/%0d want=0/1", out_valid, taken_cnt); end
  endtask

  task automatic test_jumps();
    set_op(3, 3'd0, 32'h50, 32'h3, 32'h1001, 0, 0, 0);
    in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    n_checks++; if (target !== 32'h1004 || taken !== 1'b1 || misalign !== 1'b0) begin n_fail++; $display("FAIL jalr got=%h/%b/%b want=1004/1/0", target, taken, misalign); end
    out_ready = 1;
    tick(); tick(); tick();
    set_op(2, 3'd0, 32'h0, 32'h6, 0, 0, 0, 0);
    in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    n_checks++; if (target !== 32'h6 || misalign !== 1'b1 || taken !== 1'b1) begin n_fail++; $display("FAIL jal_mis got=%h/%b/%b want=6/1/1", target, misalign, taken); end
    out_ready = 1;
    #1;
    n_checks++; if (redirect !== 1'b0 || redirect_pc !== 0) begin n_fail++; $display("FAIL jal_noredir got=%b/%h want=0/0", redirect, redirect_pc); end
    tick();
    n_checks++; if (taken_cnt !== 16'd3 || in_ready !== 1'b1) begin n_fail++; $display("FAIL jal_cnt got=%0d/%b want=3/1", taken_cnt, in_ready); end
  endtask

  task automatic test_illegal();
    set_op(1, 3'd2, 32'hFFFF_FFFC, 32'h10, 0, 1, 1, 1);
    in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    n_checks++; if (illegal !== 1'b1 || taken !== 1'b0) begin n_fail++; $display("FAIL illegal got=%b/%b want=1/0", illegal, taken); end
    n_checks++; if (link !== 32'h0) begin n_fail++; $display("FAIL link_wrap got=%h want=0", link); end
    out_ready = 1;
    tick();
  endtask

  task automatic test_stall_and_reset();
    logic [XLEN-1:0] t0;
    set_op(1, 3'd4, 32'h400, 32'hFFFF_FFF0, 0, 0, 1, 0);
    in_valid = 1; out_ready = 0;
    tick();
    t0 = 32'h3F0;
    set_op(1, 3'd0, 32'h800, 32'h4, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1 || target !== t0 || taken !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL hold%0d got=%b/%h/%b/%b want=1/%h/1/0", i, out_valid, target, taken, in_ready, t0); end
    end
    in_valid = 0; out_ready = 1;
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_flush got=%b want=0", in_ready); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || taken_cnt !== 16'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_flush got=%b/%0d/%b want=0/0/1", out_valid, taken_cnt, in_ready); end
  endtask

  task automatic test_random();
    bit   m_full = 0;
    res_t m_res;
    res_t nr;
    int   m_stall = 0;
    int   m_cnt = 0;
    bit   m_redir, exp_ready, acc, hs;
    m_res = '{default: '0};
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      set_op($urandom_range(0, 3), 3'($urandom), ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom,
             ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom, $urandom,
             1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      m_redir = m_full && m_res.taken && !m_res.misalign && !m_res.illegal;
      exp_ready = (m_stall == 0) && (!m_full || (out_ready && !m_redir));
      n_checks++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_in_ready c=%0d got=%b want=%b", c, in_ready, exp_ready); end
      n_checks++; if (out_valid !== m_full) begin n_fail++; $display("FAIL rnd_out_valid c=%0d got=%b want=%b", c, out_valid, m_full); end
      n_checks++; if (redirect !== (m_redir && out_ready) || redirect_pc !== ((m_redir && out_ready) ? m_res.target : 32'd0)) begin n_fail++; $display("FAIL rnd_redirect c=%0d got=%b/%h", c, redirect, redirect_pc); end
      n_checks++; if (taken_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt c=%0d got=%0d want=%0d", c, taken_cnt, m_cnt); end
      if (m_full) begin
        n_checks++;
        if (taken !== m_res.taken || misalign !== m_res.misalign || illegal !== m_res.illegal ||
            target !== m_res.target || link !== m_res.link) begin
          n_fail++;
          $display("FAIL rnd_fields c=%0d got=%b%b%b/%h/%h want=%b%b%b/%h/%h", c, taken, misalign,
                   illegal, target, link, m_res.taken, m_res.misalign, m_res.illegal,
                   m_res.target, m_res.link);
        end
      end
      nr = model_resolve();
      acc = in_valid && exp_ready;
      hs = m_full && out_ready;
      tick();
      if (rst) begin
        m_full = 0; m_stall = 0; m_cnt = 0;
      end else begin
        if (m_stall > 0) m_stall--;
        if (hs) begin
          if (m_res.taken && m_cnt < 65535) m_cnt++;
          if (m_redir) m_stall = FLUSH;
          m_full = 0;
        end
        if (acc) begin
          m_full = 1;
          m_res = nr;
        end
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_beq_redirect();
    test_back_to_back();
    test_jumps();
    test_illegal();
    test_stall_and_reset();
    test_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
